// File: rtl/i2c_byte_master.sv
// Byte-level I2C master sequencer driven by the timing generator's quarter-phase data_clk.
// Shifts START, address+R/W, data bytes, ACK/NACK and STOP onto open-drain SDA and gates SCL.
module i2c_byte_master (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_clk,
    input  logic       ena,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] data_wr,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       scl_not_ena,
    output logic       busy,
    output logic       byte_done,
    output logic [7:0] data_rd,
    output logic       ack_error
);
    // state    | meaning
    // READY    | idle, both lines released, waiting for ena on a data_clk rise
    // START    | SDA pulled low while SCL is still released (START condition)
    // COMMAND  | shifting address + R/W, MSB first
    // SLV_ACK1 | slave acknowledges the address byte
    // WR       | shifting a write byte, MSB first
    // RD       | sampling a read byte from the slave, MSB first
    // SLV_ACK2 | slave acknowledges a write byte; decide continue or stop
    // MSTR_ACK | master ACKs (continue) or NACKs (last) a read byte
    // STOP     | SCL released with SDA low, then SDA released (STOP condition)
    typedef enum logic [3:0] {
        READY, START, COMMAND, SLV_ACK1, WR, RD, SLV_ACK2, MSTR_ACK, STOP
    } state_t;

    state_t     state_q, state_d;
    logic       data_clk_q;
    logic [7:0] addr_rw_q, addr_rw_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] data_rd_q, data_rd_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       sda_q, sda_d;
    logic       scl_ne_q, scl_ne_d;
    logic       busy_q, busy_d;
    logic       bd_q, bd_d;
    logic       ack_err_q, ack_err_d;
    logic       rise, fall, same_req;

    assign rise     = data_clk & ~data_clk_q;
    assign fall     = ~data_clk & data_clk_q;
    assign same_req = ena && ({addr, rw} == addr_rw_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= READY;
            data_clk_q <= 1'b0;
            addr_rw_q  <= 8'h00;
            tx_q       <= 8'h00;
            rx_q       <= 8'h00;
            data_rd_q  <= 8'h00;
            bit_cnt_q  <= 3'd7;
            sda_q      <= 1'b1;
            scl_ne_q   <= 1'b1;
            busy_q     <= 1'b0;
            bd_q       <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_clk_q <= data_clk;
            addr_rw_q  <= addr_rw_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            data_rd_q  <= data_rd_d;
            bit_cnt_q  <= bit_cnt_d;
            sda_q      <= sda_d;
            scl_ne_q   <= scl_ne_d;
            busy_q     <= busy_d;
            bd_q       <= bd_d;
            ack_err_q  <= ack_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_rw_d = addr_rw_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        data_rd_d = data_rd_q;
        bit_cnt_d = bit_cnt_q;
        sda_d     = sda_q;
        scl_ne_d  = scl_ne_q;
        busy_d    = busy_q;
        bd_d      = 1'b0;
        ack_err_d = ack_err_q;
        case (state_q)
            READY: begin
                sda_d    = 1'b1;
                scl_ne_d = 1'b1;
                busy_d   = 1'b0;
                if (rise && ena) begin
                    addr_rw_d = {addr, rw};
                    tx_d      = data_wr;
                    ack_err_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                if (fall) begin
                    sda_d = 1'b0;
                end else if (rise) begin
                    state_d   = COMMAND;
                    scl_ne_d  = 1'b0;
                    sda_d     = addr_rw_q[7];
                    bit_cnt_d = 3'd7;
                end
            end
            COMMAND: begin
                if (rise) begin
                    if (bit_cnt_q != 3'd0) begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        sda_d     = addr_rw_q[bit_cnt_d];
                    end else begin
                        sda_d   = 1'b1;
                        state_d = SLV_ACK1;
                    end
                end
            end
            SLV_ACK1: begin
                if (fall) begin
                    if (sda_in) ack_err_d = 1'b1;
                end else if (rise) begin
                    bit_cnt_d = 3'd7;
                    if (!addr_rw_q[0]) begin
                        state_d = WR;
                        sda_d   = tx_q[7];
                    end else begin
                        state_d = RD;
                        sda_d   = 1'b1;
                    end
                end
            end
            WR: begin
                if (rise) begin
                    if (bit_cnt_q != 3'd0) begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        sda_d     = tx_q[bit_cnt_d];
                    end else begin
                        sda_d   = 1'b1;
                        bd_d    = 1'b1;
                        state_d = SLV_ACK2;
                    end
                end
            end
            RD: begin
                if (fall) begin
                    rx_d[bit_cnt_q] = sda_in;
                end else if (rise) begin
                    if (bit_cnt_q != 3'd0) begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end else begin
                        data_rd_d = rx_q;
                        bd_d      = 1'b1;
                        state_d   = MSTR_ACK;
                        // ACK only when the same request is still pending
                        sda_d     = ~same_req;
                    end
                end
            end
            SLV_ACK2: begin
                if (fall) begin
                    if (sda_in) ack_err_d = 1'b1;
                end else if (rise) begin
                    if (same_req) begin
                        tx_d      = data_wr;
                        state_d   = WR;
                        sda_d     = data_wr[7];
                        bit_cnt_d = 3'd7;
                    end else begin
                        state_d  = STOP;
                        sda_d    = 1'b0;
                        scl_ne_d = 1'b1;
                    end
                end
            end
            MSTR_ACK: begin
                if (rise) begin
                    if (same_req) begin
                        state_d   = RD;
                        sda_d     = 1'b1;
                        bit_cnt_d = 3'd7;
                    end else begin
                        state_d  = STOP;
                        sda_d    = 1'b0;
                        scl_ne_d = 1'b1;
                    end
                end
            end
            STOP: begin
                if (fall) begin
                    sda_d = 1'b1;
                end else if (rise) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = READY;
        endcase
    end

    assign sda_out     = sda_q;
    assign scl_not_ena = scl_ne_q;
    assign busy        = busy_q;
    assign byte_done   = bd_q;
    assign data_rd     = data_rd_q;
    assign ack_error   = ack_err_q;
endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master: quarter-phase data_clk generator, bus monitor and
// a simple slave model indexed by data_clk period within the transaction.
module tb_i2c_byte_master;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = 7'h00;
    logic [7:0] data_wr = 8'h00;
    logic       sda_in;
    logic       sda_out, scl_not_ena, busy, byte_done, ack_error;
    logic [7:0] data_rd;

    int         ph = 0;
    logic       data_clk = 1'b0, scl_gen = 1'b0, freeze = 1'b0, slave_sda = 1'b1, nd;
    int         slot = 0, final_slot = 0, start_cnt = 0, stop_cnt = 0, rd_n = 0, bd_wide = 0;
    logic       sda_prev = 1'b1, scl_prev = 1'b1, bd_prev = 1'b0, sda_now, scl_now;
    logic [0:63] log_b = '1;
    logic [7:0] rd_log [0:15];
    logic       rw_mode = 1'b0, addr_ack = 1'b1, data_ack = 1'b1;
    logic [7:0] rd_bytes [0:3];
    int         n_checks = 0, n_fail = 0;

    assign sda_in = sda_out & slave_sda;

    i2c_byte_master dut (
        .clk(clk), .rst(rst), .data_clk(data_clk), .ena(ena), .addr(addr), .rw(rw),
        .data_wr(data_wr), .sda_in(sda_in), .sda_out(sda_out), .scl_not_ena(scl_not_ena),
        .busy(busy), .byte_done(byte_done), .data_rd(data_rd), .ack_error(ack_error)
    );

    always #5 clk = ~clk;

    // slot 0 = START period, 1..8 address, 9 ack, then 9 slots per byte (8 bits + ack)
    function automatic logic slave_bit(input int s);
        int j, p;
        if (s <= 8) return 1'b1;
        if (s == 9) return addr_ack ? 1'b0 : 1'b1;
        j = (s - 10) / 9;
        p = (s - 10) % 9;
        if (p == 8) return (rw_mode || !data_ack) ? 1'b1 : 1'b0;
        if (rw_mode && j < 4) return rd_bytes[j][7-p];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        sda_now = sda_out & slave_sda;
        scl_now = scl_not_ena | scl_gen;
        if (scl_prev && scl_now && sda_prev && !sda_now) start_cnt++;
        if (scl_prev && scl_now && !sda_prev && sda_now) stop_cnt++;
        sda_prev = sda_now;
        scl_prev = scl_now;
        if (byte_done) begin
            if (rd_n < 16) rd_log[rd_n] = data_rd;
            rd_n++;
            if (bd_prev) bd_wide++;
        end
        bd_prev = byte_done;
        if (!freeze) begin
            ph = (ph + 1) % 16;
            nd = (ph >= 4 && ph < 12);
            scl_gen = (ph >= 8);
            if (nd && !data_clk) begin
                if (busy) begin
                    slot++;
                    final_slot = slot;
                end else begin
                    slot = 0;
                end
                slave_sda = slave_bit(slot);
            end
            if (!nd && data_clk && busy && slot < 64) log_b[slot] = sda_out & slave_sda;
            data_clk = nd;
        end
    end

    task automatic wait_busy(input logic lvl, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === lvl) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_bd(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (byte_done === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_slot(input int s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (slot == s) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({sda_out, scl_not_ena} !== 2'b11) begin n_fail++; $display("FAIL reset_lines: got %b want 11", {sda_out, scl_not_ena}); end
        n_checks++; if ({busy, byte_done, ack_error} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, byte_done, ack_error}); end
        n_checks++; if (data_rd !== 8'h00) begin n_fail++; $display("FAIL reset_data_rd: got %h want 00", data_rd); end
    endtask

    task automatic test_idle;
        int b_start;
        b_start = start_cnt;
        repeat (100) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
        n_checks++; if (start_cnt - b_start != 0) begin n_fail++; $display("FAIL idle_start: got %0d want 0", start_cnt - b_start); end
    endtask

    task automatic test_write_single;
        bit ok;
        int b_start, b_stop, b_rd;
        b_start = start_cnt; b_stop = stop_cnt; b_rd = rd_n;
        addr = 7'h50; rw = 1'b0; data_wr = 8'hA5; rw_mode = 1'b0; addr_ack = 1'b1; data_ack = 1'b1;
        ena = 1'b1;
        wait_busy(1'b1, 64, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wr1_accept: busy stayed 0, want 1"); end
        ena = 1'b0;
        wait_busy(1'b0, 2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wr1_finish: busy stayed 1, want 0"); end
        repeat (4) @(negedge clk);
        n_checks++; if (start_cnt - b_start != 1) begin n_fail++; $display("FAIL wr1_start: got %0d want 1", start_cnt - b_start); end
        n_checks++; if (stop_cnt - b_stop != 1) begin n_fail++; $display("FAIL wr1_stop: got %0d want 1", stop_cnt - b_stop); end
        n_checks++; if (log_b[1 +: 8] !== 8'hA0) begin n_fail++; $display("FAIL wr1_addr: got %h want a0", log_b[1 +: 8]); end
        n_checks++; if (log_b[10 +: 8] !== 8'hA5) begin n_fail++; $display("FAIL wr1_data: got %h want a5", log_b[10 +: 8]); end
        n_checks++; if ({log_b[9], log_b[18]} !== 2'b00) begin n_fail++; $display("FAIL wr1_acks: got %b want 00", {log_b[9], log_b[18]}); end
        n_checks++; if (final_slot != 20) begin n_fail++; $display("FAIL wr1_busy_len: got %0d want 20", final_slot); end
        n_checks++; if (ack_error !== 1'b0) begin n_fail++; $display("FAIL wr1_ack_error: got %b want 0", ack_error); end
        n_checks++; if (rd_n - b_rd != 1) begin n_fail++; $display("FAIL wr1_byte_done: got %0d want 1", rd_n - b_rd); end
        n_checks++; if ({sda_out, scl_not_ena} !== 2'b11) begin n_fail++; $display("FAIL wr1_idle_lines: got %b want 11", {sda_out, scl_not_ena}); end
    endtask

    task automatic test_read;
        bit ok;
        int b_stop, b_rd;
        b_stop = stop_cnt; b_rd = rd_n;
        rd_bytes[0] = 8'h3C; rd_bytes[1] = 8'hC3; rd_bytes[2] = 8'hFF; rd_bytes[3] = 8'hFF;
        addr = 7'h21; rw = 1'b1; rw_mode = 1'b1; addr_ack = 1'b1;
        ena = 1'b1;
        wait_bd(2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rd_byte1: no byte_done, want pulse"); end
        wait_slot(19, 200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rd_slot19: slot %0d, want 19", slot); end
        repeat (3) @(negedge clk);
        ena = 1'b0;
        wait_busy(1'b0, 2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rd_finish: busy stayed 1, want 0"); end
        repeat (4) @(negedge clk);
        n_checks++; if (rd_n - b_rd != 2) begin n_fail++; $display("FAIL rd_count: got %0d want 2", rd_n - b_rd); end
        n_checks++; if (rd_log[b_rd] !== 8'h3C) begin n_fail++; $display("FAIL rd_data1: got %h want 3c", rd_log[b_rd]); end
        n_checks++; if (rd_log[b_rd+1] !== 8'hC3) begin n_fail++; $display("FAIL rd_data2: got %h want c3", rd_log[b_rd+1]); end
        n_checks++; if (log_b[1 +: 8] !== 8'h43) begin n_fail++; $display("FAIL rd_addr: got %h want 43", log_b[1 +: 8]); end
        n_checks++; if ({log_b[18], log_b[27]} !== 2'b01) begin n_fail++; $display("FAIL rd_mstr_ack: got %b want 01", {log_b[18], log_b[27]}); end
        n_checks++; if (stop_cnt - b_stop != 1) begin n_fail++; $display("FAIL rd_stop: got %0d want 1", stop_cnt - b_stop); end
        n_checks++; if (final_slot != 29) begin n_fail++; $display("FAIL rd_busy_len: got %0d want 29", final_slot); end
        rw_mode = 1'b0; rw = 1'b0;
    endtask

    task automatic test_addr_nack;
        bit ok;
        int b_stop;
        b_stop = stop_cnt;
        addr = 7'h3B; rw = 1'b0; data_wr = 8'h5E; addr_ack = 1'b0; data_ack = 1'b1;
        ena = 1'b1;
        wait_busy(1'b1, 64, ok);
        ena = 1'b0;
        wait_slot(12, 400, ok);
        n_checks++; if (ack_error !== 1'b1) begin n_fail++; $display("FAIL nack_flag_mid: got %b want 1", ack_error); end
        wait_busy(1'b0, 2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL nack_finish: busy stayed 1, want 0"); end
        repeat (4) @(negedge clk);
        n_checks++; if (ack_error !== 1'b1) begin n_fail++; $display("FAIL nack_flag_sticky: got %b want 1", ack_error); end
        n_checks++; if (log_b[10 +: 8] !== 8'h5E) begin n_fail++; $display("FAIL nack_data: got %h want 5e", log_b[10 +: 8]); end
        n_checks++; if (stop_cnt - b_stop != 1) begin n_fail++; $display("FAIL nack_stop: got %0d want 1", stop_cnt - b_stop); end
        addr_ack = 1'b1; addr = 7'h3B; data_wr = 8'h01;
        ena = 1'b1;
        wait_busy(1'b1, 64, ok);
        ena = 1'b0;
        n_checks++; if (ack_error !== 1'b0) begin n_fail++; $display("FAIL nack_clear: got %b want 0", ack_error); end
        wait_busy(1'b0, 2000, ok);
        repeat (4) @(negedge clk);
        n_checks++; if (ack_error !== 1'b0) begin n_fail++; $display("FAIL nack_clean_txn: got %b want 0", ack_error); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int b_start, b_stop;
        b_start = start_cnt; b_stop = stop_cnt;
        addr = 7'h50; rw = 1'b0; data_wr = 8'h11;
        ena = 1'b1;
        wait_bd(2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_byte1: no byte_done, want pulse"); end
        data_wr = 8'h22;
        wait_bd(2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_byte2: no byte_done, want pulse"); end
        ena = 1'b0;
        wait_busy(1'b0, 2000, ok);
        repeat (4) @(negedge clk);
        n_checks++; if (log_b[10 +: 8] !== 8'h11) begin n_fail++; $display("FAIL b2b_data1: got %h want 11", log_b[10 +: 8]); end
        n_checks++; if (log_b[19 +: 8] !== 8'h22) begin n_fail++; $display("FAIL b2b_data2: got %h want 22", log_b[19 +: 8]); end
        n_checks++; if (start_cnt - b_start != 1 || stop_cnt - b_stop != 1) begin n_fail++; $display("FAIL b2b_framing: got start %0d stop %0d want 1 1", start_cnt - b_start, stop_cnt - b_stop); end
        n_checks++; if (final_slot != 29) begin n_fail++; $display("FAIL b2b_busy_len: got %0d want 29", final_slot); end
    endtask

    task automatic test_stretch;
        bit ok;
        int b_rd;
        b_rd = rd_n;
        addr = 7'h5A; rw = 1'b0; data_wr = 8'hC9;
        ena = 1'b1;
        wait_busy(1'b1, 64, ok);
        ena = 1'b0;
        wait_slot(13, 400, ok);
        repeat (6) @(negedge clk);
        freeze = 1'b1;
        repeat (500) @(negedge clk);
        freeze = 1'b0;
        wait_busy(1'b0, 2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL str_finish: busy stayed 1, want 0"); end
        repeat (4) @(negedge clk);
        n_checks++; if (log_b[1 +: 8] !== 8'hB4) begin n_fail++; $display("FAIL str_addr: got %h want b4", log_b[1 +: 8]); end
        n_checks++; if (log_b[10 +: 8] !== 8'hC9) begin n_fail++; $display("FAIL str_data: got %h want c9", log_b[10 +: 8]); end
        n_checks++; if (final_slot != 20) begin n_fail++; $display("FAIL str_busy_len: got %0d want 20", final_slot); end
        n_checks++; if (rd_n - b_rd != 1) begin n_fail++; $display("FAIL str_byte_done: got %0d want 1", rd_n - b_rd); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int b_start, b_stop;
        addr = 7'h66; rw = 1'b0; data_wr = 8'h0F;
        ena = 1'b1;
        wait_busy(1'b1, 64, ok);
        ena = 1'b0;
        wait_slot(13, 400, ok);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if ({sda_out, scl_not_ena, busy} !== 3'b110) begin n_fail++; $display("FAIL rstmid_lines: got %b want 110", {sda_out, scl_not_ena, busy}); end
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        b_start = start_cnt; b_stop = stop_cnt;
        addr = 7'h12; data_wr = 8'h96;
        ena = 1'b1;
        wait_busy(1'b1, 64, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_accept: busy stayed 0, want 1"); end
        ena = 1'b0;
        wait_busy(1'b0, 2000, ok);
        repeat (4) @(negedge clk);
        n_checks++; if (log_b[1 +: 8] !== 8'h24) begin n_fail++; $display("FAIL rstmid_addr: got %h want 24", log_b[1 +: 8]); end
        n_checks++; if (log_b[10 +: 8] !== 8'h96) begin n_fail++; $display("FAIL rstmid_data: got %h want 96", log_b[10 +: 8]); end
        n_checks++; if (start_cnt - b_start != 1 || stop_cnt - b_stop != 1) begin n_fail++; $display("FAIL rstmid_framing: got start %0d stop %0d want 1 1", start_cnt - b_start, stop_cnt - b_stop); end
        n_checks++; if (final_slot != 20) begin n_fail++; $display("FAIL rstmid_busy_len: got %0d want 20", final_slot); end
    endtask

    initial begin
        test_reset;
        test_idle;
        test_write_single;
        test_read;
        test_addr_nack;
        test_back_to_back;
        test_stretch;
        test_reset_mid;
        n_checks++; if (bd_wide != 0) begin n_fail++; $display("FAIL byte_done_width: got %0d wide pulses want 0", bd_wide); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
